dma_frame_seq: RTL

Multi-frame sequencer for the RDMA/WDMA engine pair in the FFT/IFFT accelerator. It replaces the single-shot start/stop glue. From one `ap_start` it runs the read and write engines for `num_frames` consecutive frames, advancing each engine's base address by a programmable stride per frame. It sits between the host control registers and the `rdma`/`wdma` control ports. The AXI and stream paths bypass it.

---
 rtl/dma_frame_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dma_frame_seq.sv
// dma_frame_seq: runs RDMA/WDMA for num_frames frames, striding each base address.
// Define DMA_SEQ_LAG_LIMIT_EN to hold RDMA within MAX_LAG frames of WDMA.
module dma_frame_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_LAG    = 2
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  ap_ready,
  input  logic [LEN_WIDTH-1:0]  rdma_transfer_byte,
  input  logic [LEN_WIDTH-1:0]  wdma_transfer_byte,
  input  logic [ADDR_WIDTH-1:0] rdma_mem_ptr,
  input  logic [ADDR_WIDTH-1:0] wdma_mem_ptr,
  input  logic [ADDR_WIDTH-1:0] rdma_stride,
  input  logic [ADDR_WIDTH-1:0] wdma_stride,
  input  logic [CNT_WIDTH-1:0]  num_frames,
  output logic                  rdma_ap_start,
  input  logic                  rdma_ap_ready,
  input  logic                  rdma_ap_done,
  output logic [ADDR_WIDTH-1:0] rdma_base_addr,
  output logic [LEN_WIDTH-1:0]  rdma_len,
  output logic                  wdma_ap_start,
  input  logic                  wdma_ap_ready,
  input  logic                  wdma_ap_done,
  output logic [ADDR_WIDTH-1:0] wdma_base_addr,
  output logic [LEN_WIDTH-1:0]  wdma_len,
  output logic [CNT_WIDTH-1:0]  rd_frames_done,
  output logic [CNT_WIDTH-1:0]  wr_frames_done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} top_e;
  typedef enum logic [1:0] {C_IDLE, C_START, C_BUSY, C_END} ch_e;

`ifdef DMA_SEQ_LAG_LIMIT_EN
  localparam bit LagEn = 1'b1;
`else
  localparam bit LagEn = 1'b0;
`endif
  localparam logic [CNT_WIDTH:0] LagW = (CNT_WIDTH+1)'(MAX_LAG);

  top_e top_q, top_d;
  ch_e  rd_st_q, rd_st_d, wr_st_q, wr_st_d;
  logic start_q;
  logic rd_go_q, wr_go_q, idle_q, done_q;
  logic [CNT_WIDTH-1:0]  nf_q, nf_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_str_q, rd_str_d, wr_str_q, wr_str_d;
  logic [LEN_WIDTH-1:0]  rd_len_q, rd_len_d, wr_len_q, wr_len_d;

  logic launch, rd_fin, wr_fin, rd_more, wr_more, rd_gate, run_n;
  logic [CNT_WIDTH:0] rd_lim;

  function automatic ch_e ch_next(ch_e st, logic run, logic fin,
                                  logic rdy, logic more, logic gate);
    ch_e nx;
    nx = st;
    if (!run) begin
      nx = C_IDLE;
    end else begin
      unique case (st)
        C_IDLE:  if (more && gate) nx = C_START;
        C_START: begin
          if (fin) nx = !more ? C_END : (gate ? C_START : C_IDLE);
          else if (rdy) nx = C_BUSY;
        end
        C_BUSY:  if (fin) nx = !more ? C_END : (gate ? C_START : C_IDLE);
        C_END:   nx = C_END;
        default: nx = C_IDLE;
      endcase
    end
    return nx;
  endfunction

  always_comb begin
    launch = (top_q == IDLE) & ap_start & ~start_q;
    // same-cycle ready+done in C_START completes the frame outright
    rd_fin = rdma_ap_done & ((rd_st_q == C_BUSY) |
             ((rd_st_q == C_START) & rdma_ap_ready));
    wr_fin = wdma_ap_done & ((wr_st_q == C_BUSY) |
             ((wr_st_q == C_START) & wdma_ap_ready));
  end

  always_comb begin
    nf_d      = nf_q;
    rd_len_d  = rd_len_q;
    wr_len_d  = wr_len_q;
    rd_str_d  = rd_str_q;
    wr_str_d  = wr_str_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (launch) begin
      nf_d      = num_frames;
      rd_len_d  = rdma_transfer_byte;
      wr_len_d  = wdma_transfer_byte;
      rd_str_d  = rdma_stride;
      wr_str_d  = wdma_stride;
      rd_addr_d = rdma_mem_ptr;
      wr_addr_d = wdma_mem_ptr;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
    end else begin
      if (rd_fin) begin
        rd_cnt_d  = rd_cnt_q + CNT_WIDTH'(1);
        rd_addr_d = rd_addr_q + rd_str_q;
      end
      if (wr_fin) begin
        wr_cnt_d  = wr_cnt_q + CNT_WIDTH'(1);
        wr_addr_d = wr_addr_q + wr_str_q;
      end
    end
  end

  always_comb begin
    rd_more = rd_cnt_d < nf_d;
    wr_more = wr_cnt_d < nf_d;
    rd_lim  = {1'b0, wr_cnt_d} + LagW;
    rd_gate = ~LagEn | ({1'b0, rd_cnt_d} < rd_lim);
  end

  always_comb begin
    top_d = top_q;
    unique case (top_q)
      IDLE:    if (launch) top_d = (num_frames == '0) ? FIN : RUN;
      RUN:     if (!rd_more && !wr_more) top_d = FIN;
      FIN:     top_d = IDLE;
      default: top_d = IDLE;
    endcase
    run_n   = (top_d == RUN);
    rd_st_d = ch_next(rd_st_q, run_n, rd_fin, rdma_ap_ready,
                      rd_more, rd_gate);
    wr_st_d = ch_next(wr_st_q, run_n, wr_fin, wdma_ap_ready,
                      wr_more, 1'b1);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      top_q     <= IDLE;
      rd_st_q   <= C_IDLE;
      wr_st_q   <= C_IDLE;
      start_q   <= 1'b0;
      rd_go_q   <= 1'b0;
      wr_go_q   <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      nf_q      <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_str_q  <= '0;
      wr_str_q  <= '0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
    end else begin
      top_q     <= top_d;
      rd_st_q   <= rd_st_d;
      wr_st_q   <= wr_st_d;
      start_q   <= ap_start;
      rd_go_q   <= (rd_st_d == C_START);
      wr_go_q   <= (wr_st_d == C_START);
      idle_q    <= (top_d == IDLE);
      done_q    <= (top_d == FIN);
      nf_q      <= nf_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_str_q  <= rd_str_d;
      wr_str_q  <= wr_str_d;
      rd_len_q  <= rd_len_d;
      wr_len_q  <= wr_len_d;
    end
  end

  assign ap_idle        = idle_q;
  assign ap_done        = done_q;
  assign ap_ready       = done_q;
  assign rdma_ap_start  = rd_go_q;
  assign wdma_ap_start  = wr_go_q;
  assign rdma_base_addr = rd_addr_q;
  assign wdma_base_addr = wr_addr_q;
  assign rdma_len       = rd_len_q;
  assign wdma_len       = wr_len_q;
  assign rd_frames_done = rd_cnt_q;
  assign wr_frames_done = wr_cnt_q;

endmodule
